// File: rtl/mul_div_pkg.sv
// Definitions shared by the multiply and divide units: handshake FSM states
// and the signed-overflow detector used when an operation is accepted.
package mul_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_div_state_e;

    // Most-negative dividend over -1 cannot be represented as a signed quotient.
    function automatic logic is_signed_overflow(input logic div_signed,
                                                input logic dvd_is_min,
                                                input logic dvs_is_ones);
        return div_signed & dvd_is_min & dvs_is_ones;
    endfunction

endpackage

// File: rtl/divider_if.sv
// Request/response bundle between the execute stage and the divider.
interface divider_if #(
    parameter int XLEN = 32
);
    logic            inready;
    logic            invalid;
    logic            flush;
    logic            div_signed;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            outvalid;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    modport master (
        input  inready, outvalid, quotient, remainder,
        output invalid, flush, div_signed, dividend, divisor
    );

    modport slave (
        output inready, outvalid, quotient, remainder,
        input  invalid, flush, div_signed, dividend, divisor
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract
// the divisor magnitude in XLEN+1 bits, keep the difference when non-negative.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);
    logic        [XLEN:0] shifted;
    logic signed [XLEN:0] trial;

    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        // The true difference lies in [-dvs, dvs), so the XLEN+1-bit sign is exact.
        trial   = $signed(shifted - {1'b0, dvs});
        if (!trial[XLEN]) begin
            rem_out = trial[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = shifted[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/divider.sv
// Iterative restoring integer divider with RISC-V M semantics for divide by
// zero and signed overflow; fixed latency from accept to result.
module divider
    import mul_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst,
    divider_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    mul_div_state_e   state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem, quo, dvs_mag, dvd_raw;
    logic [XLEN-1:0]  rem_step, quo_step;
    logic [XLEN-1:0]  quotient_q, remainder_q;
    logic             neg_q, neg_r, div_zero, sovf;
    logic             accept, last_step, dvd_neg, dvs_neg;

    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    assign accept    = (state == IDLE) && bus.invalid && !bus.flush;
    assign last_step = (cnt == CNT_W'(XLEN - 1));
    assign dvd_neg   = bus.div_signed & bus.dividend[XLEN-1];
    assign dvs_neg   = bus.div_signed & bus.divisor[XLEN-1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (last_step) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= '0;
            else if (state == CALC)
                cnt <= cnt + 1'b1;
        end
    end

    // Accept: capture magnitudes, sign fixups and special-case flags
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_raw  <= bus.dividend;
            rem      <= '0;
            quo      <= cond_neg(dvd_neg, bus.dividend);
            dvs_mag  <= cond_neg(dvs_neg, bus.divisor);
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            div_zero <= (bus.divisor == '0);
            sovf     <= is_signed_overflow(bus.div_signed,
                                           bus.dividend == {1'b1, {(XLEN-1){1'b0}}},
                                           &bus.divisor);
        end else if (state == CALC) begin
            rem <= rem_step;
            quo <= quo_step;
        end
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .dvs     (dvs_mag),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    // FIX: sign correction and special cases into the held result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            quotient_q  <= '0;
            remainder_q <= '0;
        end else if (state == FIX && !bus.flush) begin
            if (div_zero) begin
                quotient_q  <= '1;
                remainder_q <= dvd_raw;
            end else if (sovf) begin
                quotient_q  <= dvd_raw;
                remainder_q <= '0;
            end else begin
                quotient_q  <= cond_neg(neg_q, quo);
                remainder_q <= cond_neg(neg_r, rem);
            end
        end
    end

    assign bus.inready   = (state == IDLE);
    assign bus.outvalid  = (state == DONE);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
endmodule

// File: doc/divider.md
# divider

Iterative radix-2 restoring integer divider: the inverse companion to the team's multiplier, sharing its invalid/inready/outvalid/flush handshake so the execute stage drives both units identically. It accepts one XLEN-bit divide per handshake and produces quotient and remainder after a fixed latency. It follows RISC-V M semantics for division by zero and signed overflow.

## Interface
- XLEN, 32, operand/result width; any even value ≥ 8
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- inready  out  1  unit idle, will accept a request this cycle
- invalid  in  1  request valid; accepted when invalid & inready at a rising edge
- flush  in  1  abort in-flight operation, synchronous
- div_signed  in  1  1: both operands two's complement; 0: both unsigned
- dividend  in  XLEN  numerator, sampled at acceptance only
- divisor  in  XLEN  denominator, sampled at acceptance only
- outvalid  out  1  one-cycle pulse, quotient/remainder valid
- quotient  out  XLEN  result quotient, held until next acceptance
- remainder  out  XLEN  result remainder, held until next acceptance

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: inready=1. On accept: latch sign flags, absolute values (signed mode) or raw operands, special-case flags; clear partial remainder; counter=0; go CALC.
- CALC: one restoring step per cycle: shift {rem,quo} left 1, trial-subtract divisor magnitude in XLEN+1 bits, keep result and set quotient bit if non-negative. After XLEN steps go FIX.
- FIX: apply signs (quotient negated if signs differ, remainder takes dividend sign); apply special cases; register outputs; go DONE.
- DONE: outvalid=1 for exactly one cycle; go IDLE.
- Divide by zero: quotient = all ones, remainder = dividend (original, unsigned or signed).
- Signed overflow (dividend = 1<<(XLEN-1), divisor = all ones, div_signed=1): quotient = dividend, remainder = 0.
- Special cases keep the full fixed latency; no early-out.
- invalid while not IDLE: ignored, not queued.
- flush: next state IDLE from any state; outvalid suppressed for the aborted op; quotient/remainder keep previous values. Flush with invalid in IDLE: flush wins, no accept. Flush while in DONE: outvalid still asserted that cycle (result already complete).
- rst low at an edge: state IDLE, counter 0, quotient/remainder 0; overrides flush and invalid.

## Timing
- Reset values: inready=1, outvalid=0, quotient=0, remainder=0.
- Accept at edge N; CALC steps on edges N+1..N+XLEN; FIX at edge N+XLEN+1 → outvalid high from edge N+XLEN+1 to N+XLEN+2; inready high again after edge N+XLEN+2.
- XLEN=32: 34 cycles from accept to next possible accept.
- inready, outvalid decoded from registered state only; no input→output combinational path.
- Counter width $clog2(XLEN)+1.

## Structure
- Shared package mul_div_pkg: state enum (IDLE/CALC/FIX/DONE), shared with the multiplier's handshake states; helper for signed-overflow detection.
- One sub-module natural: div_step, combinational single restoring step (shift, XLEN+1-bit trial subtract, select), instantiated once in CALC datapath.
- Top: FSM, counter, operand/sign registers, FIX logic.

## Test plan
- Unsigned 100 / 7 → quotient 0x0000000E, remainder 0x00000002, outvalid exactly 33 edges after accept, one cycle wide.
- Signed 0xFFFFFFF9 / 0x00000002 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; same operands unsigned → 0x7FFFFFFC, 0x00000001.
- Signed 0x80000010 / 0 → quotient 0xFFFFFFFF, remainder 0x80000010, same latency.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; unsigned same → quotient 0, remainder 0x80000000.
- Flush 10 cycles after accept → no outvalid, inready=1 next cycle; then unsigned 0x80000010 / 4 → quotient 0x20000004, remainder 0; invalid pulsed mid-CALC ignored.
- rst low mid-CALC → next cycle inready=1, outvalid=0, quotient=remainder=0; subsequent 16 / 4 signed → quotient 4, remainder 0.
